// File: rtl/binary_maxpool_pkg.sv
// Shared constants, FSM encoding and legal-width helpers for the binary max-pool engine.
package binary_maxpool_pkg;

  localparam int unsigned POOL_ADDR_W    = 12;
  localparam int unsigned POOL_DATA_W    = 16;
  localparam logic [15:0] POOL_TERM_WORD = 16'h00FF;

  // Widest legal image is 14 columns, pooled down to 7.
  localparam int unsigned ROW_IN_W  = 14;
  localparam int unsigned ROW_OUT_W = 7;

  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_HDR   = 6'b000010,
    S_ROW_A = 6'b000100,
    S_ROW_B = 6'b001000,
    S_WR    = 6'b010000,
    S_TERM  = 6'b100000
  } pool_state_e;

  function automatic logic legal_w(input logic [4:0] w);
    return (w == 5'd8) || (w == 5'd10) || (w == 5'd14);
  endfunction

  // Valid pooled columns for each legal width; zero for anything else.
  function automatic logic [ROW_OUT_W-1:0] col_mask(input logic [4:0] w);
    case (w)
      5'd8:    col_mask = 7'h0F;
      5'd10:   col_mask = 7'h1F;
      5'd14:   col_mask = 7'h7F;
      default: col_mask = '0;
    endcase
  endfunction

endpackage

// File: rtl/binary_maxpool_if.sv
// Start/busy handshake plus the read and write SRAM ports of the max-pool engine.
interface binary_maxpool_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16
);
  logic              pool_run;
  logic              pool_busy;
  logic [ADDR_W-1:0] pool_sram_read_address;
  logic [DATA_W-1:0] sram_pool_read_data;
  logic [ADDR_W-1:0] pool_sram_write_address;
  logic [DATA_W-1:0] pool_sram_write_data;
  logic              pool_sram_write_enable;

  modport master (
    input  pool_run, sram_pool_read_data,
    output pool_busy, pool_sram_read_address, pool_sram_write_address,
           pool_sram_write_data, pool_sram_write_enable
  );

  modport slave (
    output pool_run, sram_pool_read_data,
    input  pool_busy, pool_sram_read_address, pool_sram_write_address,
           pool_sram_write_data, pool_sram_write_enable
  );
endinterface

// File: rtl/pool_row_reduce.sv
// 2x2 binary max-pool of one row pair: OR of both rows over each adjacent column pair.
module pool_row_reduce
  import binary_maxpool_pkg::*;
(
  input  logic [ROW_IN_W-1:0]  row_even,
  input  logic [ROW_IN_W-1:0]  row_odd,
  output logic [ROW_OUT_W-1:0] pooled
);

  for (genvar c = 0; c < ROW_OUT_W; c++) begin : g_col
    assign pooled[c] = row_even[2*c] | row_even[2*c+1] | row_odd[2*c] | row_odd[2*c+1];
  end

endmodule

// File: rtl/binary_maxpool.sv
// Streams binary images from the conv-output SRAM, 2x2 max-pools them and writes
// headers, pooled rows and a terminator to the pooled-output SRAM.
module binary_maxpool
  import binary_maxpool_pkg::*;
#(
  parameter int unsigned       ADDR_W    = POOL_ADDR_W,
  parameter int unsigned       DATA_W    = POOL_DATA_W,
  parameter logic [DATA_W-1:0] TERM_WORD = DATA_W'(POOL_TERM_WORD)
) (
  input logic              clk,
  input logic              reset,
  binary_maxpool_if.master bus
);

  pool_state_e          state, state_next;
  logic [ADDR_W-1:0]    rd_addr, wr_addr;
  logic [DATA_W-1:0]    wr_data, wr_data_next;
  logic                 wr_en, wr_en_next, busy;
  logic [ROW_IN_W-1:0]  row_even;
  logic [2:0]           half, row_cnt;
  logic [ROW_OUT_W-1:0] mask, pooled;
  logic [DATA_W-1:0]    rdata;
  logic [4:0]           hdr_w;
  logic                 hdr_legal, last_row;

  assign rdata     = bus.sram_pool_read_data;
  assign hdr_w     = rdata[4:0];
  assign hdr_legal = (rdata != TERM_WORD) && legal_w(hdr_w);
  assign last_row  = (row_cnt == half - 3'd1);

  pool_row_reduce u_reduce (
    .row_even (row_even),
    .row_odd  (rdata[ROW_IN_W-1:0]),
    .pooled   (pooled)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Write strobe/data are computed one state early so each registered write
  // lands in the cycle after the word that produced it.
  always_comb begin
    state_next   = state;
    wr_en_next   = 1'b0;
    wr_data_next = '0;
    case (state)
      S_IDLE:  if (bus.pool_run) state_next = S_HDR;
      S_HDR: begin
        wr_en_next = 1'b1;
        if (hdr_legal) begin
          state_next        = S_ROW_A;
          wr_data_next[3:0] = rdata[4:1];
        end else begin
          state_next   = S_TERM;
          wr_data_next = TERM_WORD;
        end
      end
      S_ROW_A: state_next = S_ROW_B;
      S_ROW_B: begin
        state_next                       = S_WR;
        wr_en_next                       = 1'b1;
        wr_data_next[ROW_OUT_W-1:0]      = pooled & mask;
      end
      S_WR:    state_next = last_row ? S_HDR : S_ROW_A;
      S_TERM:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr  <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_en    <= 1'b0;
      busy     <= 1'b0;
      row_even <= '0;
      half     <= '0;
      mask     <= '0;
      row_cnt  <= '0;
    end else begin
      wr_en   <= wr_en_next;
      wr_data <= wr_data_next;
      busy    <= (state_next != S_IDLE);

      // Read address runs one word ahead: it steps whenever the next state consumes a word.
      if (state_next == S_IDLE)
        rd_addr <= '0;
      else if (state_next inside {S_HDR, S_ROW_A, S_ROW_B})
        rd_addr <= rd_addr + ADDR_W'(1);

      if (state_next == S_IDLE) wr_addr <= '0;
      else if (wr_en)           wr_addr <= wr_addr + ADDR_W'(1);

      if (state == S_HDR && hdr_legal) begin
        half    <= rdata[3:1];
        mask    <= col_mask(hdr_w);
        row_cnt <= '0;
      end
      if (state == S_ROW_A) row_even <= rdata[ROW_IN_W-1:0];
      if (state == S_WR)    row_cnt  <= row_cnt + 3'd1;
    end
  end

  assign bus.pool_busy               = busy;
  assign bus.pool_sram_read_address  = rd_addr;
  assign bus.pool_sram_write_address = wr_addr;
  assign bus.pool_sram_write_data    = wr_data;
  assign bus.pool_sram_write_enable  = wr_en;

endmodule

// File: tb/tb_binary_maxpool.sv
// Directed bench for binary_maxpool: SRAM models, write scoreboard and hand-computed golden tables.
module tb_binary_maxpool;
  import binary_maxpool_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic clr   = 1'b0;

  always #5 clk = ~clk;

  binary_maxpool_if #(.ADDR_W(12), .DATA_W(16)) bus ();

  binary_maxpool #(.ADDR_W(12), .DATA_W(16), .TERM_WORD(16'h00FF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] in_mem  [64];
  logic [15:0] out_mem [64];
  int          wr_cyc  [64];
  int          cyc = 0, wr_cnt = 0, term_cyc = 0, busy_fall_cyc = 0, run_cyc = 0;
  logic        run_seen = 1'b0, busy_q = 1'b0;
  logic [11:0] term_rd_addr = '0;
  int          passed = 0, total = 0;

  // W=10 then W=8, including junk bits above each image width.
  logic [15:0] img3 [21] = '{16'h000A,
    16'h0001, 16'h0000, 16'h0000, 16'h0200, 16'h00C0, 16'h0004, 16'h0155, 16'h0000, 16'hFC00, 16'h0000,
    16'h0008,
    16'h0080, 16'h0002, 16'h0030, 16'h0000, 16'h0300, 16'h0000, 16'h00FF, 16'h00FF,
    16'h00FF};
  logic [15:0] exp3 [12] = '{16'h0005, 16'h0001, 16'h0010, 16'h000A, 16'h001F, 16'h0000,
                             16'h0004, 16'h0009, 16'h0004, 16'h0000, 16'h000F, 16'h00FF};

  always @(posedge clk) bus.sram_pool_read_data <= in_mem[bus.pool_sram_read_address[5:0]];

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    busy_q <= bus.pool_busy;
    if (clr) begin
      for (int i = 0; i < 64; i++) begin
        out_mem[i] <= 16'hDEAD;
        wr_cyc[i]  <= 0;
      end
      wr_cnt <= 0; term_cyc <= 0; busy_fall_cyc <= 0; run_cyc <= 0;
      run_seen <= 1'b0; term_rd_addr <= '0;
    end else begin
      if (bus.pool_run && !run_seen) begin
        run_cyc  <= cyc;
        run_seen <= 1'b1;
      end
      if (bus.pool_sram_write_enable) begin
        out_mem[bus.pool_sram_write_address[5:0]] <= bus.pool_sram_write_data;
        wr_cyc[bus.pool_sram_write_address[5:0]]  <= cyc;
        wr_cnt <= wr_cnt + 1;
        if (bus.pool_sram_write_data == 16'h00FF) begin
          term_cyc     <= cyc;
          term_rd_addr <= bus.pool_sram_read_address;
        end
      end
      if (busy_q && !bus.pool_busy) busy_fall_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_sb();
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
  endtask

  task automatic zero_in();
    for (int i = 0; i < 64; i++) in_mem[i] = 16'h0000;
  endtask

  task automatic start_run(input string tag);
    @(negedge clk) bus.pool_run = 1'b1;
    @(negedge clk) bus.pool_run = 1'b0;
    check({tag, "_busy_rise"}, 32'(bus.pool_busy), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n = 0;
    while (bus.pool_busy === 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(bus.pool_busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_img3(input string tag);
    for (int i = 0; i < 12; i++)
      check($sformatf("%s_out%0d", tag, i), 32'(out_mem[i]), 32'(exp3[i]));
    check({tag, "_wr_cnt"}, 32'(wr_cnt), 32'd12);
    check({tag, "_rd_addr_end"}, 32'(term_rd_addr), 32'd21);
    check({tag, "_term_lat"}, 32'(term_cyc - run_cyc), 32'd31);
  endtask

  initial begin
    bus.pool_run = 1'b0;
    zero_in();
    clr = 1'b1;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    check("rst_busy",  32'(bus.pool_busy), 32'd0);
    check("rst_wen",   32'(bus.pool_sram_write_enable), 32'd0);
    check("rst_raddr", 32'(bus.pool_sram_read_address), 32'd0);
    check("rst_waddr", 32'(bus.pool_sram_write_address), 32'd0);
    check("rst_wdata", 32'(bus.pool_sram_write_data), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_no_start", 32'(bus.pool_busy), 32'd0);
    check("idle_no_write", 32'(wr_cnt), 32'd0);

    // Single W=8 image, only row 3 = 8'h10
    zero_in();
    in_mem[0] = 16'h0008; in_mem[4] = 16'h0010; in_mem[9] = 16'h00FF;
    clear_sb();
    start_run("t1");
    wait_idle("t1");
    check("t1_hdr",  32'(out_mem[0]), 32'h0004);
    check("t1_row0", 32'(out_mem[1]), 32'h0000);
    check("t1_row1", 32'(out_mem[2]), 32'h0004);
    check("t1_row2", 32'(out_mem[3]), 32'h0000);
    check("t1_row3", 32'(out_mem[4]), 32'h0000);
    check("t1_term", 32'(out_mem[5]), 32'h00FF);
    check("t1_wr_cnt", 32'(wr_cnt), 32'd6);
    check("t1_hdr_lat",  32'(wr_cyc[0] - run_cyc), 32'd2);
    check("t1_row0_lat", 32'(wr_cyc[1] - run_cyc), 32'd4);
    check("t1_row1_lat", 32'(wr_cyc[2] - run_cyc), 32'd7);
    check("t1_row3_lat", 32'(wr_cyc[4] - run_cyc), 32'd13);
    check("t1_term_lat", 32'(term_cyc - run_cyc), 32'd15);
    check("t1_busy_fall", 32'(busy_fall_cyc - term_cyc), 32'd1);
    check("t1_rd_addr_end", 32'(term_rd_addr), 32'd10);
    check("t1_waddr_idle", 32'(bus.pool_sram_write_address), 32'd0);

    // W=14, all-ones rows
    zero_in();
    in_mem[0] = 16'h000E;
    for (int i = 1; i <= 14; i++) in_mem[i] = 16'h3FFF;
    in_mem[15] = 16'h00FF;
    clear_sb();
    start_run("t2");
    wait_idle("t2");
    check("t2_hdr", 32'(out_mem[0]), 32'h0007);
    for (int i = 1; i <= 7; i++) check($sformatf("t2_row%0d", i - 1), 32'(out_mem[i]), 32'h007F);
    check("t2_term", 32'(out_mem[8]), 32'h00FF);
    check("t2_wr_cnt", 32'(wr_cnt), 32'd9);
    check("t2_busy_fall", 32'(busy_fall_cyc - term_cyc), 32'd1);

    // Back-to-back W=10 then W=8
    zero_in();
    for (int i = 0; i < 21; i++) in_mem[i] = img3[i];
    clear_sb();
    start_run("t3");
    wait_idle("t3");
    check_img3("t3");

    // Illegal W=12 header terminates at once
    zero_in();
    in_mem[0] = 16'h000C; in_mem[1] = 16'h1234;
    clear_sb();
    start_run("t4");
    wait_idle("t4");
    check("t4_term", 32'(out_mem[0]), 32'h00FF);
    check("t4_wr_cnt", 32'(wr_cnt), 32'd1);
    check("t4_rd_addr_end", 32'(term_rd_addr), 32'd1);

    // Reset during the row-2 write of a W=14 image
    zero_in();
    in_mem[0] = 16'h000E;
    for (int i = 1; i <= 14; i++) in_mem[i] = 16'h3FFF;
    in_mem[15] = 16'h00FF;
    clear_sb();
    start_run("t5");
    begin
      int unsigned n = 0;
      logic found = 1'b0;
      while (!found && n < 100) begin
        @(negedge clk);
        if (bus.pool_sram_write_enable === 1'b1 && bus.pool_sram_write_address === 12'd3) found = 1'b1;
        n++;
      end
      check("t5_row2_seen", 32'(found), 32'd1);
    end
    reset = 1'b1;
    #1;
    check("t5_wen_low",  32'(bus.pool_sram_write_enable), 32'd0);
    check("t5_busy_low", 32'(bus.pool_busy), 32'd0);
    check("t5_raddr",    32'(bus.pool_sram_read_address), 32'd0);
    check("t5_waddr",    32'(bus.pool_sram_write_address), 32'd0);
    check("t5_fsm_idle", 32'(dut.state), 32'(S_IDLE));
    @(negedge clk) reset = 1'b0;
    repeat (20) @(negedge clk);
    check("t5_wr_cnt", 32'(wr_cnt), 32'd3);
    check("t5_no_restart", 32'(bus.pool_busy), 32'd0);

    // pool_run toggled throughout the run must not disturb it
    zero_in();
    for (int i = 0; i < 21; i++) in_mem[i] = img3[i];
    clear_sb();
    start_run("t6");
    begin
      int unsigned n = 0;
      while (bus.pool_busy === 1'b1 && n < 300) begin
        @(negedge clk);
        bus.pool_run = ~bus.pool_run;
        n++;
      end
      bus.pool_run = 1'b0;
    end
    wait_idle("t6");
    check_img3("t6");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

endmodule

// File: doc/binary_maxpool.md
BINARY_MAXPOOL -- requirements
Module: binary_maxpool

Interface
REQ-001 Parameter ADDR_W, default 12, SRAM address width.
REQ-002 Parameter DATA_W, default 16, SRAM word width.
REQ-003 Parameter TERM_WORD, default 16'h00FF, end-of-stream header value.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 pool_run  input  1  start pulse; sampled only in IDLE.
REQ-007 pool_busy  output  1  high from the cycle after pool_run is accepted until the terminator has been written.
REQ-008 pool_sram_read_address  output  ADDR_W  registered read address into the conv-output SRAM.
REQ-009 sram_pool_read_data  input  DATA_W  read data, valid 1 cycle after the address register updates.
REQ-010 pool_sram_write_address  output  ADDR_W  registered write address into the pooled-output SRAM.
REQ-011 pool_sram_write_data  output  DATA_W  registered write data.
REQ-012 pool_sram_write_enable  output  1  registered write strobe, one word per high cycle.

Function
REQ-013 Input stream starts at address 0 and is a sequence of images, each one header word (W in bits [4:0], W in {8,10,14}) followed by W row words (bit i = column i), ending with TERM_WORD.
REQ-014 Each image is reduced by a 2x2 stride-2 binary max-pool: out[r][c] = in[2r][2c] | in[2r][2c+1] | in[2r+1][2c] | in[2r+1][2c+1], for r,c in 0..W/2-1.
REQ-015 Output stream starts at address 0: one header word {11'd0, W/2} per image, then W/2 row words with bits [DATA_W-1:W/2] zero; after the last image, TERM_WORD is written.
REQ-016 FSM states: IDLE, HDR, ROW_A, ROW_B, WR, TERM; one-hot encoded.
REQ-017 IDLE->HDR on pool_run; HDR->ROW_A on a valid header (header word written same cycle); HDR->TERM on TERM_WORD or on any W not in {8,10,14}.
REQ-018 ROW_A captures even row; ROW_B captures odd row; WR writes pooled row; WR->ROW_A while rows remain, WR->HDR after row W/2-1.
REQ-019 TERM writes TERM_WORD, deasserts pool_busy the following cycle, returns to IDLE.
REQ-020 Read address increments by 1 per consumed word, continuous across images; it is not reset between images.
REQ-021 Write address increments by 1 after every asserted write-enable cycle; returns to 0 on entry to IDLE.
REQ-022 A pooled row is written exactly 1 cycle after its odd input row's data is valid.
REQ-023 pool_run while busy is ignored; no other handshake exists.
REQ-024 Address counters wrap modulo 2^ADDR_W with no error flag.
REQ-025 Write-enable is never high for more than W/2+1 consecutive cycles within one image (header + rows).

Reset
REQ-026 On reset: FSM=IDLE, pool_busy=0, write enable=0, both addresses=0, write data=0, row/dim registers=0.
REQ-027 Reset asserted mid-image aborts immediately; no further writes occur until a new pool_run after reset release.
REQ-028 Reset deassertion takes effect on the next rising edge; no operation starts without pool_run.

Structure
REQ-029 Shared package holds ADDR_W, DATA_W, TERM_WORD, the legal-W set, and the FSM state encoding.
REQ-030 One sub-module, pool_row_reduce: combinational OR of two rows and adjacent column pairs, output width 7.
REQ-031 Datapath is pure OR/compaction; no arithmetic beyond address and row counters.

Verification
REQ-032 Single W=8 image, all rows 8'h00 except in row 3 = 8'h10 -> header 16'h0004, row1 = 16'h0004, others 0, then 16'h00FF at address 5.
REQ-033 W=14 image of all-ones rows -> header 16'h0007, seven rows of 16'h007F, terminator at address 8, pool_busy low one cycle later.
REQ-034 Back-to-back images W=10 then W=8 -> headers at write addresses 0 and 6, terminator at 11; read address ends at 21.
REQ-035 Header 16'h000C (W=12) at address 0 -> immediate TERM: single write of 16'h00FF at address 0.
REQ-036 Reset pulsed during WR of row 2 (W=14) -> write enable low in the same cycle, FSM IDLE, addresses 0, no writes after release until pool_run.
REQ-037 pool_run pulsed repeatedly during busy -> output identical to single-run golden model.
